// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, dispenser states
// and the greedy coin selection used by the change dispenser.
package vm_pkg;

    localparam int COIN_N = 5;
    localparam int COIN_D = 10;
    localparam int COIN_Q = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_GAP,
        ST_FINISH
    } disp_state_t;

    typedef enum logic [1:0] {
        PICK_NONE,
        PICK_Q,
        PICK_D,
        PICK_N
    } coin_t;

    // Largest coin that fits the remainder and is still in stock
    function automatic coin_t pick_coin(
        input int   rem,
        input logic have_q,
        input logic have_d,
        input logic have_n
    );
        coin_t c;
        c = PICK_NONE;
        if (rem >= COIN_Q && have_q)
            c = PICK_Q;
        else if (rem >= COIN_D && have_d)
            c = PICK_D;
        else if (rem >= COIN_N && have_n)
            c = PICK_N;
        return c;
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-coin stock counter; reloads on reset or refill and
// saturates at zero on decrement.
module coin_inventory #(
    parameter int CNT_W = 5,
    parameter int INIT  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_refill,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_empty
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= CNT_W'(INIT);
        else if (i_refill)
            r_cnt <= CNT_W'(INIT);
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_cnt   = r_cnt;
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy, inventory-aware coin ejection
// with optional idle gap between pulses and registered outputs.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W      = 7,
    parameter int CNT_W      = 5,
    parameter int INIT_Q     = 8,
    parameter int INIT_D     = 8,
    parameter int INIT_N     = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req,
    input  logic [AMT_W-1:0] i_amount,
    input  logic             i_refill,
    output logic             o_busy,
    output logic             o_eject_q,
    output logic             o_eject_d,
    output logic             o_eject_n,
    output logic             o_done,
    output logic             o_short,
    output logic [AMT_W-1:0] o_remain,
    output logic [CNT_W-1:0] o_cnt_q,
    output logic [CNT_W-1:0] o_cnt_d,
    output logic [CNT_W-1:0] o_cnt_n
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_t      r_state;
    disp_state_t      w_next;
    logic [AMT_W-1:0] r_rem;
    logic [GW-1:0]    r_gap;
    logic             r_busy;
    logic             r_ej_q;
    logic             r_ej_d;
    logic             r_ej_n;
    logic             r_done;
    logic             r_short;
    logic [AMT_W-1:0] r_remain;

    coin_t w_pick;
    logic  w_empty_q;
    logic  w_empty_d;
    logic  w_empty_n;
    logic  w_refill;
    logic  w_accept;
    logic  w_dec_q;
    logic  w_dec_d;
    logic  w_dec_n;
    logic  w_eject;
    logic  w_sel_end;

    assign w_pick = pick_coin(int'(r_rem), !w_empty_q,
                              !w_empty_d, !w_empty_n);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!i_refill && i_req)
                    w_next = ST_SELECT;
            end
            ST_SELECT: begin
                if (w_pick == PICK_NONE)
                    w_next = ST_FINISH;
                else if (GAP_CYCLES > 0)
                    w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == '0)
                    w_next = ST_SELECT;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_refill  = 1'b0;
        w_accept  = 1'b0;
        w_dec_q   = 1'b0;
        w_dec_d   = 1'b0;
        w_dec_n   = 1'b0;
        w_sel_end = 1'b0;
        if (r_state == ST_IDLE) begin
            w_refill = i_refill;
            w_accept = !i_refill && i_req;
        end
        if (r_state == ST_SELECT) begin
            w_dec_q   = (w_pick == PICK_Q);
            w_dec_d   = (w_pick == PICK_D);
            w_dec_n   = (w_pick == PICK_N);
            w_sel_end = (w_pick == PICK_NONE);
        end
    end

    assign w_eject = w_dec_q | w_dec_d | w_dec_n;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rem    <= '0;
            r_gap    <= '0;
            r_busy   <= 1'b0;
            r_ej_q   <= 1'b0;
            r_ej_d   <= 1'b0;
            r_ej_n   <= 1'b0;
            r_done   <= 1'b0;
            r_short  <= 1'b0;
            r_remain <= '0;
        end else begin
            r_ej_q <= w_dec_q;
            r_ej_d <= w_dec_d;
            r_ej_n <= w_dec_n;
            r_done <= (r_state == ST_FINISH);
            if (w_accept) begin
                r_rem  <= i_amount;
                r_busy <= 1'b1;
            end
            if (w_sel_end)
                r_busy <= 1'b0;
            if (w_dec_q)
                r_rem <= r_rem - AMT_W'(COIN_Q);
            else if (w_dec_d)
                r_rem <= r_rem - AMT_W'(COIN_D);
            else if (w_dec_n)
                r_rem <= r_rem - AMT_W'(COIN_N);
            // Loaded with G-1 so GAP lasts exactly G cycles
            if (w_eject)
                r_gap <= GW'(GAP_CYCLES - 1);
            else if (r_state == ST_GAP && r_gap != '0)
                r_gap <= r_gap - GW'(1);
            if (r_state == ST_FINISH) begin
                r_short  <= (r_rem != '0);
                r_remain <= r_rem;
            end
        end
    end

    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_Q)) u_inv_q (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_refill (w_refill),
        .i_dec    (w_dec_q),
        .o_cnt    (o_cnt_q),
        .o_empty  (w_empty_q)
    );

    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_D)) u_inv_d (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_refill (w_refill),
        .i_dec    (w_dec_d),
        .o_cnt    (o_cnt_d),
        .o_empty  (w_empty_d)
    );

    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_N)) u_inv_n (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_refill (w_refill),
        .i_dec    (w_dec_n),
        .o_cnt    (o_cnt_n),
        .o_empty  (w_empty_n)
    );

    assign o_busy    = r_busy;
    assign o_eject_q = r_ej_q;
    assign o_eject_d = r_ej_d;
    assign o_eject_n = r_ej_n;
    assign o_done    = r_done;
    assign o_short   = r_short;
    assign o_remain  = r_remain;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: four instances cover default,
// quarter-depleted, short-stock and gapped configurations.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] amount;
    logic       req    [4];
    logic       refill [4];
    logic       busy   [4];
    logic       eq     [4];
    logic       ed     [4];
    logic       en     [4];
    logic       done   [4];
    logic       shrt   [4];
    logic [6:0] remain [4];
    logic [4:0] cq     [4];
    logic [4:0] cd     [4];
    logic [4:0] cn     [4];

    int    checks = 0;
    int    errors = 0;
    string seq;
    int    dc;
    int    acc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        change_dispenser #(
            .INIT_Q     (g == 1 ? 1 : (g == 2 ? 0 : 8)),
            .INIT_D     (g == 2 ? 0 : 8),
            .INIT_N     (g == 2 ? 1 : 8),
            .GAP_CYCLES (g == 3 ? 2 : 0)
        ) u_dut (
            .i_clk     (clk),
            .i_reset   (rst),
            .i_req     (req[g]),
            .i_amount  (amount),
            .i_refill  (refill[g]),
            .o_busy    (busy[g]),
            .o_eject_q (eq[g]),
            .o_eject_d (ed[g]),
            .o_eject_n (en[g]),
            .o_done    (done[g]),
            .o_short   (shrt[g]),
            .o_remain  (remain[g]),
            .o_cnt_q   (cq[g]),
            .o_cnt_d   (cd[g]),
            .o_cnt_n   (cn[g])
        );
    end

    function automatic string s(input int v);
        return $sformatf("%0d", v);
    endfunction

    task automatic chk(input string tag, input string got,
                       input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%s exp=%s", tag, got, exp);
        end
    endtask

    function automatic int nej(input int i);
        return int'(eq[i]) + int'(ed[i]) + int'(en[i]);
    endfunction

    // One payout; seq holds one symbol per cycle until DONE
    task automatic pay(input int i, input int amt, input int poke,
                       output string sq, output int dcyc);
        amount = 7'(amt);
        req[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[i] = 1'b0;
        chk($sformatf("busy_up%0d", i), s(busy[i]), "1");
        sq   = "";
        dcyc = -1;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            if (c == poke) begin
                req[i]    = 1'b1;
                refill[i] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            req[i]    = 1'b0;
            refill[i] = 1'b0;
            if (done[i])
                dcyc = c;
            else if (nej(i) > 1)
                sq = {sq, "X"};
            else if (eq[i])
                sq = {sq, "Q"};
            else if (ed[i])
                sq = {sq, "D"};
            else if (en[i])
                sq = {sq, "N"};
            else
                sq = {sq, "-"};
        end
    endtask

    initial begin
        rst    = 1'b1;
        amount = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]    = 1'b0;
            refill[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", s(busy[0]), "0");
        chk("rst_done", s(done[0]), "0");
        chk("rst_short", s(shrt[0]), "0");
        chk("rst_remain", s(remain[0]), "0");
        chk("rst_ej", s(nej(0)), "0");
        chk("rst_cq", s(cq[0]), "8");
        chk("rst_cd", s(cd[0]), "8");
        chk("rst_cn", s(cn[0]), "8");
        chk("rst_cn2", s(cn[2]), "1");
        rst = 1'b0;
        @(negedge clk);

        pay(0, 40, 0, seq, dc);
        chk("mix_seq", seq, "QDN-");
        chk("mix_done", s(dc), "5");
        chk("mix_busy", s(busy[0]), "0");
        chk("mix_short", s(shrt[0]), "0");
        chk("mix_remain", s(remain[0]), "0");
        chk("mix_cq", s(cq[0]), "7");
        chk("mix_cd", s(cd[0]), "7");
        chk("mix_cn", s(cn[0]), "7");

        pay(1, 50, 0, seq, dc);
        chk("dep_seq", seq, "QDDN-");
        chk("dep_done", s(dc), "6");
        chk("dep_short", s(shrt[1]), "0");
        chk("dep_cq", s(cq[1]), "0");
        chk("dep_cd", s(cd[1]), "6");
        chk("dep_cn", s(cn[1]), "7");

        pay(2, 15, 0, seq, dc);
        chk("sho_seq", seq, "N-");
        chk("sho_done", s(dc), "3");
        chk("sho_short", s(shrt[2]), "1");
        chk("sho_remain", s(remain[2]), "10");
        chk("sho_cn", s(cn[2]), "0");

        pay(0, 7, 0, seq, dc);
        chk("odd_seq", seq, "N-");
        chk("odd_done", s(dc), "3");
        chk("odd_short", s(shrt[0]), "1");
        chk("odd_remain", s(remain[0]), "2");
        chk("odd_cn", s(cn[0]), "6");
        @(negedge clk);
        chk("odd_dpulse", s(done[0]), "0");
        chk("odd_hold", s(remain[0]), "2");

        pay(0, 0, 0, seq, dc);
        chk("zero_seq", seq, "-");
        chk("zero_done", s(dc), "2");
        chk("zero_short", s(shrt[0]), "0");
        chk("zero_remain", s(remain[0]), "0");

        pay(3, 30, 0, seq, dc);
        chk("gap_seq", seq, "Q--N---");
        chk("gap_done", s(dc), "8");
        chk("gap_cq", s(cq[3]), "7");
        chk("gap_cn", s(cn[3]), "7");

        pay(0, 40, 2, seq, dc);
        chk("busyreq_seq", seq, "QDN-");
        chk("busyreq_done", s(dc), "5");
        chk("busyreq_cq", s(cq[0]), "6");
        chk("busyreq_cn", s(cn[0]), "5");
        @(negedge clk);
        chk("busyreq_idle", s(busy[0]), "0");

        amount    = 7'd40;
        req[0]    = 1'b1;
        refill[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0]    = 1'b0;
        refill[0] = 1'b0;
        chk("refill_busy", s(busy[0]), "0");
        chk("refill_cq", s(cq[0]), "8");
        chk("refill_cd", s(cd[0]), "8");
        chk("refill_cn", s(cn[0]), "8");
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            acc += nej(0) + int'(done[0]) + int'(busy[0]);
        end
        chk("refill_nopay", s(acc), "0");

        amount = 7'd40;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_q", s(eq[0]), "1");
        chk("mid_cq", s(cq[0]), "7");
        #2 rst = 1'b1;
        #1;
        chk("arst_ej", s(nej(0)), "0");
        chk("arst_busy", s(busy[0]), "0");
        chk("arst_cq", s(cq[0]), "8");
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            acc += nej(0) + int'(done[0]) + int'(shrt[0]);
        end
        chk("arst_quiet", s(acc), "0");
        chk("arst_cnt", s(int'(cq[0]) + int'(cd[0]) + int'(cn[0])),
            "24");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
